// File: rtl/video_axi4s_frame_monitor_if.sv
// Bundles the monitored AXI4-Stream tap and the WISHBONE control port of the
// frame monitor. The master side drives the stream and bus; the slave side only observes.
interface video_axi4s_frame_monitor_if #(
    parameter int TUSER_WIDTH  = 1,
    parameter int TDATA_WIDTH  = 24,
    parameter int WB_ADR_WIDTH = 8,
    parameter int WB_DAT_WIDTH = 32,
    parameter int WB_SEL_WIDTH = 4
);
    logic [TUSER_WIDTH-1:0]  s_axi4s_tuser;
    logic                    s_axi4s_tlast;
    logic [TDATA_WIDTH-1:0]  s_axi4s_tdata;
    logic                    s_axi4s_tvalid;
    logic                    s_axi4s_tready;
    logic [WB_ADR_WIDTH-1:0] s_wb_adr_i;
    logic [WB_DAT_WIDTH-1:0] s_wb_dat_i;
    logic [WB_DAT_WIDTH-1:0] s_wb_dat_o;
    logic                    s_wb_we_i;
    logic [WB_SEL_WIDTH-1:0] s_wb_sel_i;
    logic                    s_wb_stb_i;
    logic                    s_wb_ack_o;

    modport master (
        output s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tvalid, s_axi4s_tready,
        output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
        input  s_wb_dat_o, s_wb_ack_o
    );

    modport slave (
        input  s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tvalid, s_axi4s_tready,
        input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
        output s_wb_dat_o, s_wb_ack_o
    );
endinterface

// File: rtl/video_axi4s_frame_monitor.sv
// Passive AXI4-Stream video frame checker: validates tuser/tlast framing against
// programmed width/height, counts good/bad frames and checksums each frame's data.
module video_axi4s_frame_monitor #(
    parameter int TUSER_WIDTH       = 1,
    parameter int TDATA_WIDTH       = 24,
    parameter int X_WIDTH           = 12,
    parameter int Y_WIDTH           = 12,
    parameter int FRAME_WIDTH       = 32,
    parameter int WB_ADR_WIDTH      = 8,
    parameter int WB_DAT_WIDTH      = 32,
    parameter int WB_SEL_WIDTH      = 4,
    parameter int INIT_PARAM_WIDTH  = 640,
    parameter int INIT_PARAM_HEIGHT = 480,
    parameter int INIT_STOP_FRAME   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    video_axi4s_frame_monitor_if.slave s_bus,
    output logic                       frame_done,
    output logic                       done
);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_ID     = 'h00;
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL    = 'h01;
    localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS = 'h02;
    localparam logic [WB_ADR_WIDTH-1:0] ADR_PW     = 'h04;
    localparam logic [WB_ADR_WIDTH-1:0] ADR_PH     = 'h05;
    localparam logic [WB_ADR_WIDTH-1:0] ADR_STOP   = 'h06;
    localparam logic [WB_ADR_WIDTH-1:0] ADR_FC     = 'h08;
    localparam logic [WB_ADR_WIDTH-1:0] ADR_BAD    = 'h09;
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CK     = 'h0A;
    localparam logic [WB_ADR_WIDTH-1:0] ADR_POS    = 'h0B;
    localparam logic [WB_DAT_WIDTH-1:0] CORE_ID    = WB_DAT_WIDTH'(32'h534D4F4E);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    function automatic logic [WB_DAT_WIDTH-1:0] wb_merge(
        input logic [WB_DAT_WIDTH-1:0] old_val,
        input logic [WB_DAT_WIDTH-1:0] wdat,
        input logic [WB_SEL_WIDTH-1:0] sel
    );
        logic [WB_DAT_WIDTH-1:0] r;
        r = old_val;
        for (int i = 0; i < WB_SEL_WIDTH; i++)
            if (sel[i]) r[i*8 +: 8] = wdat[i*8 +: 8];
        return r;
    endfunction

    // A zero dimension is treated as one so a frame always has at least one pixel.
    function automatic logic [X_WIDTH-1:0] eff_x(input logic [X_WIDTH-1:0] v);
        return (v == '0) ? X_WIDTH'(1) : v;
    endfunction

    function automatic logic [Y_WIDTH-1:0] eff_y(input logic [Y_WIDTH-1:0] v);
        return (v == '0) ? Y_WIDTH'(1) : v;
    endfunction

    state_t                  state_q, state_d;
    logic [X_WIDTH-1:0]      param_width, w_sh, wl, x_q, px;
    logic [Y_WIDTH-1:0]      param_height, h_sh, hl, y_q, py;
    logic [FRAME_WIDTH-1:0]  stop_frame, frame_count, bad_count;
    logic [31:0]             acc_q, ck_next, checksum_q;
    logic [3:0]              status_q, new_err, w1c_mask;
    logic                    err_q, err_next;
    logic                    beat, sof, wr, clr;
    logic                    start, proc, short_err, orphan, miss, early;
    logic                    last_col, line_end, frame_end;
    logic [WB_DAT_WIDTH-1:0] rd_dat;

    assign beat = s_bus.s_axi4s_tvalid & s_bus.s_axi4s_tready;
    assign sof  = s_bus.s_axi4s_tuser[0];
    assign wr   = s_bus.s_wb_stb_i & s_bus.s_wb_we_i;
    assign clr  = wr && (s_bus.s_wb_adr_i == ADR_CTL) && s_bus.s_wb_sel_i[0] && s_bus.s_wb_dat_i[0];
    assign new_err  = {early, miss, short_err, orphan};
    assign w1c_mask = (wr && (s_bus.s_wb_adr_i == ADR_STATUS) && s_bus.s_wb_sel_i[0])
                      ? s_bus.s_wb_dat_i[3:0] : 4'b0;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // A start-of-frame beat is evaluated as pixel (0,0) against freshly latched W/H.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        short_err = 1'b0;
        orphan    = 1'b0;
        proc      = 1'b0;
        miss      = 1'b0;
        early     = 1'b0;
        last_col  = 1'b0;
        line_end  = 1'b0;
        frame_end = 1'b0;
        px        = x_q;
        py        = y_q;
        wl        = w_sh;
        hl        = h_sh;
        ck_next   = acc_q;
        err_next  = err_q;
        if (beat) begin
            if (state_q == S_IDLE) begin
                if (sof) start = 1'b1;
                else     orphan = 1'b1;
            end else if (sof && (x_q != '0 || y_q != '0)) begin
                start     = 1'b1;
                short_err = 1'b1;
            end
            proc = start || (state_q == S_ACTIVE);
        end
        if (start) begin
            px = '0;
            py = '0;
            wl = eff_x(param_width);
            hl = eff_y(param_height);
        end
        if (proc) begin
            last_col  = (px == wl - X_WIDTH'(1));
            miss      = last_col & ~s_bus.s_axi4s_tlast;
            early     = s_bus.s_axi4s_tlast & ~last_col;
            line_end  = last_col | s_bus.s_axi4s_tlast;
            frame_end = line_end && (py == hl - Y_WIDTH'(1));
            ck_next   = (start ? 32'd0 : acc_q) + 32'(s_bus.s_axi4s_tdata);
            err_next  = (start ? 1'b0 : err_q) | miss | early;
            state_d   = frame_end ? S_IDLE : S_ACTIVE;
        end
        if (clr) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (proc && !clr) begin
            acc_q <= ck_next;
            if (start) begin
                w_sh <= wl;
                h_sh <= hl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            err_q        <= 1'b0;
            status_q     <= '0;
            frame_count  <= '0;
            bad_count    <= '0;
            checksum_q   <= '0;
            frame_done   <= 1'b0;
            done         <= 1'b0;
            param_width  <= X_WIDTH'(INIT_PARAM_WIDTH);
            param_height <= Y_WIDTH'(INIT_PARAM_HEIGHT);
            stop_frame   <= FRAME_WIDTH'(INIT_STOP_FRAME);
        end else begin
            frame_done <= frame_end & ~clr;
            if (clr) begin
                x_q         <= '0;
                y_q         <= '0;
                err_q       <= 1'b0;
                status_q    <= '0;
                frame_count <= '0;
                bad_count   <= '0;
                done        <= 1'b0;
            end else begin
                status_q <= (status_q & ~w1c_mask) | new_err;
                done     <= done | ((frame_count == stop_frame) && (stop_frame != '0));
                if (proc) begin
                    err_q <= err_next;
                    if (frame_end) begin
                        x_q        <= '0;
                        y_q        <= '0;
                        checksum_q <= ck_next;
                    end else if (line_end) begin
                        x_q <= '0;
                        y_q <= py + Y_WIDTH'(1);
                    end else begin
                        x_q <= px + X_WIDTH'(1);
                        y_q <= py;
                    end
                end
                // A restart with an immediately bad one-pixel frame can bump BAD_COUNT twice.
                bad_count   <= bad_count + FRAME_WIDTH'(short_err)
                                         + FRAME_WIDTH'(frame_end & err_next);
                frame_count <= frame_count + FRAME_WIDTH'(frame_end & ~err_next);
            end
            if (wr && s_bus.s_wb_adr_i == ADR_PW)
                param_width <= X_WIDTH'(wb_merge(WB_DAT_WIDTH'(param_width),
                                                 s_bus.s_wb_dat_i, s_bus.s_wb_sel_i));
            if (wr && s_bus.s_wb_adr_i == ADR_PH)
                param_height <= Y_WIDTH'(wb_merge(WB_DAT_WIDTH'(param_height),
                                                  s_bus.s_wb_dat_i, s_bus.s_wb_sel_i));
            if (wr && s_bus.s_wb_adr_i == ADR_STOP)
                stop_frame <= FRAME_WIDTH'(wb_merge(WB_DAT_WIDTH'(stop_frame),
                                                    s_bus.s_wb_dat_i, s_bus.s_wb_sel_i));
        end
    end

    always_comb begin
        rd_dat = '0;
        case (s_bus.s_wb_adr_i)
            ADR_ID:     rd_dat = CORE_ID;
            ADR_STATUS: rd_dat = WB_DAT_WIDTH'(status_q);
            ADR_PW:     rd_dat = WB_DAT_WIDTH'(param_width);
            ADR_PH:     rd_dat = WB_DAT_WIDTH'(param_height);
            ADR_STOP:   rd_dat = WB_DAT_WIDTH'(stop_frame);
            ADR_FC:     rd_dat = WB_DAT_WIDTH'(frame_count);
            ADR_BAD:    rd_dat = WB_DAT_WIDTH'(bad_count);
            ADR_CK:     rd_dat = WB_DAT_WIDTH'(checksum_q);
            ADR_POS:    rd_dat = WB_DAT_WIDTH'({16'(y_q), 16'(x_q)});
            default:    rd_dat = '0;
        endcase
    end

    assign s_bus.s_wb_dat_o = rd_dat;
    assign s_bus.s_wb_ack_o = s_bus.s_wb_stb_i;
endmodule

// File: tb/tb_video_axi4s_frame_monitor.sv
// Bench for video_axi4s_frame_monitor: register vector table, then framed
// stream sequences whose expected counters are queued and checked at frame_done.
module tb_video_axi4s_frame_monitor;
    logic clk = 1'b0;
    logic reset;
    logic frame_done, done;

    video_axi4s_frame_monitor_if bus ();

    video_axi4s_frame_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .s_bus      (bus),
        .frame_done (frame_done),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          we;
        logic [7:0]  adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [31:0] fc;
        logic [31:0] bad;
        logic [31:0] ck;
        logic [31:0] st;
    } frame_exp_t;

    reg_vec_t   vecs[$];
    frame_exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    int fd_exp = 0;
    bit stall_en = 1'b0;

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus.s_wb_adr_i = adr;
        bus.s_wb_dat_i = dat;
        bus.s_wb_sel_i = sel;
        bus.s_wb_we_i  = 1'b1;
        bus.s_wb_stb_i = 1'b1;
        @(negedge clk);
        bus.s_wb_we_i  = 1'b0;
        bus.s_wb_stb_i = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] adr, output logic [31:0] dat);
        bus.s_wb_adr_i = adr;
        bus.s_wb_we_i  = 1'b0;
        bus.s_wb_stb_i = 1'b1;
        #1;
        dat = bus.s_wb_dat_o;
        @(negedge clk);
        bus.s_wb_stb_i = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [7:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(adr, d);
        check(name, d, exp);
    endtask

    task automatic drive_beat(input logic u, input logic l, input logic [23:0] d);
        bit v, r, hit;
        hit = 1'b0;
        for (int t = 0; t < 16 && !hit; t++) begin
            v = (!stall_en || t == 15) ? 1'b1 : ($urandom_range(0, 3) != 0);
            r = (!stall_en || t == 15) ? 1'b1 : ($urandom_range(0, 2) != 0);
            bus.s_axi4s_tuser  = u;
            bus.s_axi4s_tlast  = l;
            bus.s_axi4s_tdata  = d;
            bus.s_axi4s_tvalid = v;
            bus.s_axi4s_tready = r;
            @(negedge clk);
            hit = v & r;
        end
        bus.s_axi4s_tvalid = 1'b0;
        bus.s_axi4s_tready = 1'b0;
        bus.s_axi4s_tuser  = 1'b0;
        bus.s_axi4s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int base, input int inc);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                drive_beat(x == 0 && y == 0, x == w - 1, 24'(base + (y * w + x) * inc));
    endtask

    task automatic push_frame(input logic [31:0] fc, input logic [31:0] bad,
                              input logic [31:0] ck, input logic [31:0] st);
        sb.push_back('{fc: fc, bad: bad, ck: ck, st: st});
        fd_exp++;
    endtask

    task automatic pop_check(input string tag);
        frame_exp_t e;
        #1;
        for (int i = 0; i < 20 && fd_cnt < fd_exp; i++) @(negedge clk);
        n_cmp++;
        if (fd_cnt != fd_exp || sb.size() == 0) begin
            n_err++;
            $display("FAIL %s frame_done count: got %0d required %0d", tag, fd_cnt, fd_exp);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            check_reg({tag, " FRAME_COUNT"}, 8'h08, e.fc);
            check_reg({tag, " BAD_COUNT"},   8'h09, e.bad);
            check_reg({tag, " CHECKSUM"},    8'h0A, e.ck);
            check_reg({tag, " STATUS"},      8'h02, e.st);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bus.s_axi4s_tuser = 1'b0; bus.s_axi4s_tlast = 1'b0; bus.s_axi4s_tdata = '0;
        bus.s_axi4s_tvalid = 1'b0; bus.s_axi4s_tready = 1'b0;
        bus.s_wb_adr_i = '0; bus.s_wb_dat_i = '0; bus.s_wb_we_i = 1'b0;
        bus.s_wb_sel_i = '0; bus.s_wb_stb_i = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        vecs.push_back('{"id",         1'b0, 8'h00, 32'h0,        4'h0, 32'h534D4F4E});
        vecs.push_back('{"ctl_rd",     1'b0, 8'h01, 32'h0,        4'h0, 32'h0});
        vecs.push_back('{"status_rst", 1'b0, 8'h02, 32'h0,        4'h0, 32'h0});
        vecs.push_back('{"unmap_03",   1'b0, 8'h03, 32'h0,        4'h0, 32'h0});
        vecs.push_back('{"pw_rst",     1'b0, 8'h04, 32'h0,        4'h0, 32'd640});
        vecs.push_back('{"ph_rst",     1'b0, 8'h05, 32'h0,        4'h0, 32'd480});
        vecs.push_back('{"stop_rst",   1'b0, 8'h06, 32'h0,        4'h0, 32'h0});
        vecs.push_back('{"fc_rst",     1'b0, 8'h08, 32'h0,        4'h0, 32'h0});
        vecs.push_back('{"bad_rst",    1'b0, 8'h09, 32'h0,        4'h0, 32'h0});
        vecs.push_back('{"ck_rst",     1'b0, 8'h0A, 32'h0,        4'h0, 32'h0});
        vecs.push_back('{"pos_rst",    1'b0, 8'h0B, 32'h0,        4'h0, 32'h0});
        vecs.push_back('{"unmap_0f",   1'b0, 8'h0F, 32'h0,        4'h0, 32'h0});
        vecs.push_back('{"pw_sel0",    1'b1, 8'h04, 32'hFFFFFF05, 4'h1, 32'h205});
        vecs.push_back('{"pw_sel1",    1'b1, 8'h04, 32'h00000100, 4'h2, 32'h105});
        vecs.push_back('{"pw_trunc",   1'b1, 8'h04, 32'h0000FFFF, 4'h3, 32'hFFF});
        vecs.push_back('{"ph_nosel",   1'b1, 8'h05, 32'h12345678, 4'h0, 32'd480});
        vecs.push_back('{"stop_full",  1'b1, 8'h06, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD});
        vecs.push_back('{"id_ro",      1'b1, 8'h00, 32'hFFFFFFFF, 4'hF, 32'h534D4F4E});
        vecs.push_back('{"stop_zero",  1'b1, 8'h06, 32'h0,        4'hF, 32'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].we) wb_write(vecs[i].adr, vecs[i].wdat, vecs[i].sel);
            check_reg(vecs[i].name, vecs[i].adr, vecs[i].exp);
        end

        bus.s_wb_stb_i = 1'b1; #1;
        check("ack_hi", 32'(bus.s_wb_ack_o), 32'd1);
        bus.s_wb_stb_i = 1'b0; #1;
        check("ack_lo", 32'(bus.s_wb_ack_o), 32'd0);
        @(negedge clk);

        wb_write(8'h04, 32'd4, 4'hF);
        wb_write(8'h05, 32'd3, 4'hF);

        // Clean 4x3 frame, data 1..12.
        push_frame(32'd1, 32'd0, 32'd78, 32'h0);
        send_frame(4, 3, 1, 1);
        pop_check("clean");

        // tlast at x=2 of row 1.
        wb_write(8'h01, 32'h1, 4'hF);
        check_reg("fc_cleared", 8'h08, 32'h0);
        push_frame(32'd0, 32'd1, 32'd66, 32'h8);
        for (int i = 1; i <= 4; i++) drive_beat(i == 1, i == 4, 24'(i));
        for (int i = 5; i <= 7; i++) drive_beat(1'b0, i == 7, 24'(i));
        for (int i = 8; i <= 11; i++) drive_beat(1'b0, i == 11, 24'(i));
        pop_check("early");

        // W=2, H=0 (one row), tlast never asserted.
        wb_write(8'h01, 32'h1, 4'hF);
        wb_write(8'h04, 32'd2, 4'hF);
        wb_write(8'h05, 32'd0, 4'hF);
        push_frame(32'd0, 32'd1, 32'd11, 32'h4);
        drive_beat(1'b1, 1'b0, 24'd5);
        drive_beat(1'b0, 1'b0, 24'd6);
        pop_check("missing");
        check_reg("pos_idle", 8'h0B, 32'h0);
        wb_write(8'h04, 32'd4, 4'hF);
        wb_write(8'h05, 32'd3, 4'hF);

        // Premature start of frame on the 7th beat, then a clean frame.
        wb_write(8'h01, 32'h1, 4'hF);
        push_frame(32'd1, 32'd1, 32'd1278, 32'h2);
        for (int i = 1; i <= 6; i++) drive_beat(i == 1, i == 4, 24'(i));
        send_frame(4, 3, 101, 1);
        pop_check("short");

        // Orphan beats before any start of frame, then W1C.
        wb_write(8'h01, 32'h1, 4'hF);
        for (int i = 0; i < 3; i++) drive_beat(1'b0, 1'b0, 24'(i + 7));
        check_reg("orphan_status", 8'h02, 32'h1);
        check_reg("orphan_fc", 8'h08, 32'h0);
        check_reg("orphan_bad", 8'h09, 32'h0);
        wb_write(8'h02, 32'h1, 4'h1);
        check_reg("orphan_w1c", 8'h02, 32'h0);
        check("orphan_no_fd", 32'(fd_cnt), 32'(fd_exp));

        // STOP_FRAME=2 across three frames.
        wb_write(8'h01, 32'h1, 4'hF);
        wb_write(8'h06, 32'd2, 4'hF);
        push_frame(32'd1, 32'd0, 32'd78, 32'h0);
        send_frame(4, 3, 1, 1);
        pop_check("stop_f1");
        check("done_f1", 32'(done), 32'd0);
        push_frame(32'd2, 32'd0, 32'd78, 32'h0);
        send_frame(4, 3, 1, 1);
        #1;
        check("done_same_cycle", 32'(done), 32'd0);
        @(negedge clk); #1;
        check("done_rise", 32'(done), 32'd1);
        pop_check("stop_f2");
        push_frame(32'd3, 32'd0, 32'd78, 32'h0);
        send_frame(4, 3, 1, 1);
        pop_check("stop_f3");
        check("done_sticky", 32'(done), 32'd1);
        wb_write(8'h01, 32'h1, 4'hF);
        #1;
        check("done_clear", 32'(done), 32'd0);
        wb_write(8'h06, 32'd0, 4'hF);

        // Width change mid-frame under random stalls applies only to the next frame.
        wb_write(8'h01, 32'h1, 4'hF);
        stall_en = 1'b1;
        push_frame(32'd1, 32'd0, 32'd78, 32'h0);
        for (int i = 1; i <= 5; i++) drive_beat(i == 1, i == 4, 24'(i));
        wb_write(8'h04, 32'd8, 4'hF);
        check_reg("pos_mid", 8'h0B, 32'h00010001);
        for (int i = 6; i <= 12; i++) drive_beat(1'b0, i == 8 || i == 12, 24'(i));
        pop_check("shadow_w");
        push_frame(32'd2, 32'd0, 32'd48, 32'h0);
        send_frame(8, 3, 2, 0);
        pop_check("new_w");
        stall_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
